// File: rtl/dram_rd_pkg.sv
// Shared types and AXI constants for the DRAM read master.
package dram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0]  SIZE_4B    = 3'b010;
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam int unsigned MAX_BEATS  = 16;
    localparam int unsigned PAGE_BYTES = 4096;

    // Beats for the next burst: capped by MAX_BEATS, words left, and room to the 4 KB page end.
    function automatic logic [4:0] burst_len(input logic [11:0] page_off,
                                             input logic [15:0] remaining);
        logic [12:0] page_left;
        logic [15:0] len;
        page_left = (13'(PAGE_BYTES) - {1'b0, page_off}) >> 2;
        len       = 16'(MAX_BEATS);
        if (remaining < len) begin
            len = remaining;
        end
        if (16'(page_left) < len) begin
            len = 16'(page_left);
        end
        return 5'(len);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO buffering read words toward the core.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  push_ok;
    logic                  pop_ok;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(FIFO_DEPTH)) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign valid   = valid_q;
    assign count   = count_q;

endmodule

// File: rtl/dram_read_master.sv
// AXI4 read master: splits a word-block request into 4 KB-safe INCR bursts and streams data out.
// Optional R-channel protocol checking is enabled by defining DRAM_RD_PROTOCOL_CHECK_EN.
module dram_read_master
    import dram_rd_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [CNT_WIDTH-1:0]  req_words,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   arid_s_inf,
    output logic [ADDR_WIDTH-1:0] araddr_s_inf,
    output logic [3:0]            arlen_s_inf,
    output logic [2:0]            arsize_s_inf,
    output logic [1:0]            arburst_s_inf,
    output logic                  arvalid_s_inf,
    input  logic                  arready_s_inf,
    input  logic [ID_WIDTH-1:0]   rid_s_inf,
    input  logic [DATA_WIDTH-1:0] rdata_s_inf,
    input  logic [1:0]            rresp_s_inf,
    input  logic                  rlast_s_inf,
    input  logic                  rvalid_s_inf,
    output logic                  rready_s_inf
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [4:0]            beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [3:0]            arlen_q, arlen_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  req_ready_q, req_ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  beat;
    logic                  pop;
    logic                  proto_err;
    logic [4:0]            cur_blen;
    logic [CW-1:0]         fifo_cnt;
    logic [CW-1:0]         fifo_cnt_next;
    logic                  fifo_valid;

    assign beat          = rvalid_s_inf && rready_q;
    assign pop           = fifo_valid && out_ready;
    assign fifo_cnt_next = fifo_cnt + CW'(beat) - CW'(pop);
    assign cur_blen      = 5'(arlen_q) + 5'd1;

`ifdef DRAM_RD_PROTOCOL_CHECK_EN
    // The beat counter defines the last beat; rlast and rid must agree with it.
    assign proto_err = beat && ((rid_s_inf != '0) || (rlast_s_inf != (beat_cnt_q == 5'd1)));

    always @(posedge clk) begin
        if (rst_n && proto_err) begin
            $error("dram_read_master: R beat protocol mismatch (rid=%0h rlast=%0b beats_left=%0d)",
                   rid_s_inf, rlast_s_inf, beat_cnt_q);
        end
    end
`else
    assign proto_err = 1'b0;
    wire unused_r_sideband = ^{1'b0, rid_s_inf, rlast_s_inf};
`endif

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arvalid_d   = arvalid_q;
        done_d      = 1'b0;
        err_d       = err_q | (beat && (rresp_s_inf != RESP_OKAY)) | proto_err;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    cur_addr_d  = req_addr;
                    remaining_d = req_words;
                    state_d     = (req_words == '0) ? DONE : AR;
                end
            end
            AR: begin
                if (arvalid_q && arready_s_inf) begin
                    arvalid_d   = 1'b0;
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'({cur_blen, 2'b00});
                    remaining_d = remaining_q - CNT_WIDTH'(cur_blen);
                    beat_cnt_d  = cur_blen;
                    state_d     = R;
                end
            end
            R: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q - 5'd1;
                    if (beat_cnt_q == 5'd1) begin
                        state_d = (remaining_q != '0) ? AR : DONE;
                    end
                end
            end
            DONE: begin
                // Finish only once the last word has left the FIFO.
                if (fifo_cnt_next == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Address phase is loaded on entry to AR and held stable until accepted.
        if ((state_d == AR) && (state_q != AR)) begin
            araddr_d  = cur_addr_d;
            arlen_d   = 4'(burst_len(cur_addr_d[11:0], 16'(remaining_d)) - 5'd1);
            arvalid_d = 1'b1;
        end

        rready_d    = (state_d == R) && (fifo_cnt_next < CW'(FIFO_DEPTH));
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (beat),
        .wr_data (rdata_s_inf),
        .pop     (pop),
        .rd_data (out_data),
        .valid   (fifo_valid),
        .count   (fifo_cnt)
    );

    assign out_valid     = fifo_valid;
    assign req_ready     = req_ready_q;
    assign done          = done_q;
    assign err           = err_q;
    assign arid_s_inf    = '0;
    assign araddr_s_inf  = araddr_q;
    assign arlen_s_inf   = arlen_q;
    assign arsize_s_inf  = SIZE_4B;
    assign arburst_s_inf = BURST_INCR;
    assign arvalid_s_inf = arvalid_q;
    assign rready_s_inf  = rready_q;

endmodule

// File: tb/tb_dram_read_master.sv
// Self-checking bench for dram_read_master: table of requests, DRAM slave model, scoreboards.
module tb_dram_read_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [11:0] req_words;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    dram_read_master dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_words     (req_words),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done),
        .err           (err),
        .arid_s_inf    (arid),
        .araddr_s_inf  (araddr),
        .arlen_s_inf   (arlen),
        .arsize_s_inf  (arsize),
        .arburst_s_inf (arburst),
        .arvalid_s_inf (arvalid),
        .arready_s_inf (arready),
        .rid_s_inf     (rid),
        .rdata_s_inf   (rdata),
        .rresp_s_inf   (rresp),
        .rlast_s_inf   (rlast),
        .rvalid_s_inf  (rvalid),
        .rready_s_inf  (rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
    } ar_t;

    typedef struct {
        logic [31:0] addr;
        int          words;
        bit          stall;
        int          exp_nar;
        int          exp_arlen0;
        logic [31:0] err_at;
        bit          exp_err;
    } row_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_w_q[$];
    ar_t         exp_ar_q[$];
    logic [3:0]  ar_log[$];
    int          ar_seen  = 0;
    int          rx_cnt   = 0;
    int          done_cnt = 0;
    logic [31:0] err_at   = 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    // Reference split: min(16, words left, words to page end).
    task automatic push_model(input logic [31:0] addr, input int words);
        logic [31:0] a;
        int          r;
        int          pl;
        int          b;
        ar_t         e;
        for (int i = 0; i < words; i++) begin
            exp_w_q.push_back(data_of(addr + 32'(4 * i)));
        end
        a = addr;
        r = words;
        while (r > 0) begin
            pl = (4096 - int'(a[11:0])) / 4;
            b  = (r < 16) ? r : 16;
            if (pl < b) b = pl;
            e.addr = a;
            e.len  = 4'(b - 1);
            exp_ar_q.push_back(e);
            a = a + 32'(4 * b);
            r = r - b;
        end
    endtask

    // DRAM slave: samples handshakes at negedge, updates drives just after posedge.
    initial begin : slave
        logic        ar_hs;
        logic        r_hs;
        logic [31:0] ar_a;
        logic [3:0]  ar_l;
        logic        busy;
        logic [31:0] b_addr;
        int          b_len;
        int          b_idx;
        logic [31:0] beat_addr;
        ar_t         e;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rid     = '0;
        busy    = 1'b0;
        b_addr  = '0;
        b_len   = 0;
        b_idx   = 0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            ar_a  = araddr;
            ar_l  = arlen;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy    = 1'b0;
                rvalid  = 1'b0;
                rlast   = 1'b0;
                arready = 1'b0;
                continue;
            end
            if (ar_hs) begin
                ar_seen++;
                ar_log.push_back(ar_l);
                if (exp_ar_q.size() == 0) begin
                    chk("ar_unexpected", 64'(ar_a), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_ar_q.pop_front();
                    chk("ar_addr", 64'(ar_a), 64'(e.addr));
                    chk("ar_len", 64'(ar_l), 64'(e.len));
                end
                chk("ar_4k_cross", 64'((int'(ar_a[11:0]) + 4 * (int'(ar_l) + 1)) <= 4096), 64'd1);
                busy   = 1'b1;
                b_addr = ar_a;
                b_len  = int'(ar_l);
                b_idx  = 0;
            end
            if (r_hs) begin
                b_idx++;
                if (b_idx > b_len) busy = 1'b0;
            end
            if (busy) begin
                if (!rvalid || r_hs) rvalid = ($urandom_range(3) != 0);
                beat_addr = b_addr + 32'(4 * b_idx);
                rdata     = data_of(beat_addr);
                rlast     = (b_idx == b_len);
                rresp     = (beat_addr == err_at) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
            arready = ($urandom_range(1) == 1);
        end
    end

    // Output monitor: data scoreboard and done-pulse rules.
    initial begin : monitor
        logic        prev_done;
        logic [31:0] w;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_w_q.size() == 0) begin
                    chk("out_unexpected", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    w = exp_w_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(w));
                end
                rx_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("done_while_valid", 64'(out_valid), 64'd0);
                if (prev_done) chk("done_two_cycles", 64'(prev_done), 64'd0);
            end
            prev_done = done;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
    endtask

    task automatic run_row(input row_t r);
        int ar0;
        int dc0;
        int rx0;
        int n;
        err_at = r.err_at;
        push_model(r.addr, r.words);
        ar_log.delete();
        ar0 = ar_seen;
        dc0 = done_cnt;
        rx0 = rx_cnt;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = r.addr;
        req_words = 12'(r.words);
        @(posedge clk); #1;
        // Hold a bogus request while busy; it must be ignored.
        req_addr  = 32'h0000_F000;
        req_words = 12'd3;
        req_valid = (r.words >= 8);
        @(negedge clk);
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 req_valid = 1'b0;
        if (r.stall) begin
            n = 0;
            while (rx_cnt < rx0 + 5 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("stall_start", 64'(rx_cnt >= rx0 + 5), 64'd1);
            @(posedge clk); #1 out_ready = 1'b0;
            repeat (20) @(negedge clk);
            chk("stall_rready_low", 64'(rready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1 out_ready = 1'b1;
        end
        n = 0;
        while (done_cnt == dc0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_cnt > dc0), 64'd1);
        repeat (3) @(negedge clk);
        chk("words_left", 64'(exp_w_q.size()), 64'd0);
        chk("ars_left", 64'(exp_ar_q.size()), 64'd0);
        chk("ar_count", 64'(ar_seen - ar0), 64'(r.exp_nar));
        if (ar_log.size() > 0) chk("arlen_first", 64'(ar_log[0]), 64'(r.exp_arlen0));
        chk("done_count", 64'(done_cnt - dc0), 64'd1);
        chk("err_flag", 64'(err), 64'(r.exp_err));
        chk("req_ready_idle", 64'(req_ready), 64'd1);
    endtask

    row_t tbl[8];

    initial begin : main
        int ar0;
        int rx0;
        int n;
        row_t post;
        tbl[0] = '{32'h0001_0000, 16, 1'b0, 1, 15, 32'hFFFF_FFFF, 1'b0};
        tbl[1] = '{32'h0001_0FF0, 10, 1'b0, 2,  3, 32'hFFFF_FFFF, 1'b0};
        tbl[2] = '{32'h0002_0000, 40, 1'b1, 3, 15, 32'hFFFF_FFFF, 1'b0};
        tbl[3] = '{32'h0003_0FFC,  5, 1'b0, 2,  0, 32'hFFFF_FFFF, 1'b0};
        tbl[4] = '{32'h0000_5000,  1, 1'b0, 1,  0, 32'hFFFF_FFFF, 1'b0};
        tbl[5] = '{32'h0000_6000, 17, 1'b0, 2, 15, 32'hFFFF_FFFF, 1'b0};
        tbl[6] = '{32'h0000_7000, 16, 1'b0, 1, 15, 32'h0000_7008, 1'b1};
        tbl[7] = '{32'h0000_8000,  8, 1'b0, 1,  7, 32'hFFFF_FFFF, 1'b1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_words = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 64'({req_ready, out_valid, done, err, arvalid, rready}), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_arid", 64'(arid), 64'd0);
        chk("rst_arsize", 64'(arsize), 64'd2);
        chk("rst_arburst", 64'(arburst), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_row(tbl[i]);
        end

        // Zero-word request: no AR, done two cycles after the handshake.
        ar0 = ar_seen;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_9000;
        req_words = 12'd0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("zero_done_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("zero_done_pulse", 64'(done), 64'd1);
        repeat (4) @(negedge clk);
        chk("zero_no_ar", 64'(ar_seen - ar0), 64'd0);
        chk("zero_err_sticky", 64'(err), 64'd1);

        // Reset in the middle of a 16-beat burst.
        err_at = 32'hFFFF_FFFF;
        push_model(32'h0000_A000, 16);
        rx0 = rx_cnt;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_A000;
        req_words = 12'd16;
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        while (rx_cnt < rx0 + 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_in_r", 64'(rx_cnt >= rx0 + 3), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({req_ready, out_valid, done, err, arvalid, rready}), 64'd0);
        chk("rst_mid_araddr", 64'(araddr), 64'd0);
        chk("rst_mid_arlen", 64'(arlen), 64'd0);
        exp_w_q.delete();
        exp_ar_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        post = '{32'h0000_A000, 16, 1'b0, 1, 15, 32'hFFFF_FFFF, 1'b0};
        run_row(post);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
